// File: rtl/if_fetch_pkg.sv
// ============================================================================
// Module      : if_fetch_pkg
// Description : Shared core constants, bus widths and the fetch-queue entry
//               type used by the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD        = 32'h0000_0000;
  localparam logic [INST_W-1:0]      INST_NOP         = 32'h0000_0013;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic READ_ENABLE  = 1'b1;
  localparam logic READ_DISABLE = 1'b0;

  // One queue slot: the fetch address together with the word read there.
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  localparam int ENTRY_W = INST_ADDR_W + INST_W;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : QDEPTH-entry circular FIFO with synchronous flush.
//               Ports:
//                 clk, rst      - clock, async active-low reset
//                 flush_i       - empty the queue (wins over push/pop)
//                 push_i/pop_i  - write tail / retire head
//                 wdata_i       - tail write data
//                 full_o/empty_o- occupancy flags
//                 head_o        - head entry (registered storage)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int QDEPTH = 2,
  parameter int WIDTH  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = QDEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic push_ok;
  logic pop_ok;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only honoured when the head leaves in the
  // same cycle; a pop on an empty queue is ignored.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch stage. Owns the PC, reads the
//               combinational instruction ROM, buffers {pc, inst} pairs in a
//               small queue and hands them to ID over valid/ready.
//               Ports:
//                 clk, rst           - clock, async active-low reset
//                 rom_ce_o/rom_addr_o- ROM enable and byte address (= PC)
//                 rom_inst_i         - ROM data for rom_addr_o, same cycle
//                 jump_flag_i/addr_i - redirect from EX (highest priority)
//                 id_ready_i         - ID consumes the head this cycle
//                 id_valid_o/pc_o/inst_o - head entry presented to ID
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  logic [31:0]        pc_q, pc_d;
  logic               rom_ce_q;
  logic               pop;
  logic               push;
  logic               q_full;
  logic               q_empty;
  logic [ENTRY_W-1:0] q_head;
  fetch_entry_t       head_entry;
  fetch_entry_t       tail_entry;

  assign rom_ce_o   = rom_ce_q;
  assign rom_addr_o = pc_q;

  assign pop  = id_valid_o & id_ready_i;
  // A redirect cancels the word being read this cycle; otherwise fetch
  // whenever there is room, counting the slot freed by a same-cycle pop.
  assign push = rom_ce_q & ~jump_flag_i & (~q_full | pop);

  assign tail_entry.pc   = pc_q;
  assign tail_entry.inst = rom_inst_i;

  always_comb begin
    pc_d = pc_q;
    if (jump_flag_i) begin
      pc_d = word_align(jump_addr_i);
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      rom_ce_q <= READ_DISABLE;
    end else begin
      pc_q     <= pc_d;
      rom_ce_q <= READ_ENABLE;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .WIDTH  (ENTRY_W)
  ) u_fetch_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (jump_flag_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (tail_entry),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (q_head)
  );

  assign head_entry = fetch_entry_t'(q_head);

  assign id_valid_o = ~q_empty;
  assign id_pc_o    = q_empty ? ZERO_WORD : head_entry.pc;
  assign id_inst_o  = q_empty ? INST_NOP  : head_entry.inst;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch. A queue-based model of the
//               fetch stage is compared against the DUT on every falling
//               edge; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch;

  localparam logic [31:0] ROM_KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        id_ready  = 1'b1;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ROM contents: each word is its own address XOR a fixed key.
  assign rom_inst = rom_addr ^ ROM_KEY;

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_o    (rom_ce),
    .rom_addr_o  (rom_addr),
    .rom_inst_i  (rom_inst),
    .jump_flag_i (jump_flag),
    .jump_addr_i (jump_addr),
    .id_ready_i  (id_ready),
    .id_valid_o  (id_valid),
    .id_pc_o     (id_pc),
    .id_inst_o   (id_inst)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_q[$];
  logic [31:0] m_pc = 32'h0;
  logic        m_ce = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_q.delete();
        m_pc = 32'h0;
        m_ce = 1'b0;
      end else begin
        automatic bit do_pop  = (m_q.size() > 0) && id_ready;
        automatic bit do_push = m_ce && !jump_flag && ((m_q.size() < DEPTH) || do_pop);
        if (jump_flag) begin
          m_q.delete();
          m_pc = {jump_addr[31:2], 2'b00};
        end else begin
          if (do_pop) void'(m_q.pop_front());
          if (do_push) begin
            m_q.push_back({m_pc, m_pc ^ ROM_KEY});
            m_pc = m_pc + 32'd4;
          end
        end
        m_ce = 1'b1;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    if (m_q.size() > 0) begin
      e_pc   = m_q[0][63:32];
      e_inst = m_q[0][31:0];
    end else begin
      e_pc   = 32'h0;
      e_inst = NOP;
    end
    chk("model_ce",    {31'b0, rom_ce},   {31'b0, m_ce});
    chk("model_addr",  rom_addr,          m_pc);
    chk("model_valid", {31'b0, id_valid}, {31'b0, (m_q.size() > 0)});
    chk("model_pc",    id_pc,             e_pc);
    chk("model_inst",  id_inst,           e_inst);
  end

  // Advance to just after the next falling edge, where inputs are driven.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // 1. reset and streaming start
    rst = 1'b0; id_ready = 1'b1; jump_flag = 1'b0;
    repeat (3) cyc();
    chk("rst_ce",    {31'b0, rom_ce},   32'd0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_inst",  id_inst,           NOP);
    chk("rst_pc",    id_pc,             32'h0);
    chk("rst_addr",  rom_addr,          32'h0);
    rst = 1'b1;
    cyc();
    chk("start_ce",    {31'b0, rom_ce},   32'd1);
    chk("start_valid", {31'b0, id_valid}, 32'd0);
    cyc();
    chk("s0_pc",   id_pc,   32'h0);
    chk("s0_inst", id_inst, 32'hA5A5_0000);
    chk("s0_addr", rom_addr, 32'h4);
    cyc();
    chk("s1_pc",   id_pc,   32'h4);
    chk("s1_inst", id_inst, 32'hA5A5_0004);
    cyc();
    chk("s2_pc",   id_pc,   32'h8);

    // 2. back-pressure for 5 cycles
    id_ready = 1'b0;
    repeat (5) cyc();
    chk("bp_pc",    id_pc,    32'h8);
    chk("bp_inst",  id_inst,  32'hA5A5_0008);
    chk("bp_addr",  rom_addr, 32'h10);
    chk("bp_valid", {31'b0, id_valid}, 32'd1);
    id_ready = 1'b1;
    repeat (3) cyc();
    chk("bp_release_pc", id_pc, 32'h14);

    // 3. redirect while full
    id_ready = 1'b0;
    repeat (2) cyc();
    jump_flag = 1'b1; jump_addr = 32'h0000_0103;
    cyc();
    chk("jf_valid", {31'b0, id_valid}, 32'd0);
    chk("jf_addr",  rom_addr, 32'h100);
    jump_flag = 1'b0; id_ready = 1'b1;
    cyc();
    chk("jf_pc",   id_pc,   32'h100);
    chk("jf_inst", id_inst, 32'h100 ^ ROM_KEY);

    // 4. redirect coinciding with a pop
    jump_flag = 1'b1; jump_addr = 32'h0000_0200;
    cyc();
    chk("jp_valid", {31'b0, id_valid}, 32'd0);
    chk("jp_addr",  rom_addr, 32'h200);
    jump_flag = 1'b0;
    cyc();
    chk("jp_pc0", id_pc, 32'h200);
    cyc();
    chk("jp_pc1", id_pc, 32'h204);

    // 5. PC wrap-around
    jump_flag = 1'b1; jump_addr = 32'hFFFF_FFF8;
    cyc();
    jump_flag = 1'b0;
    cyc();
    chk("wrap_pc0", id_pc, 32'hFFFF_FFF8);
    cyc();
    chk("wrap_pc1", id_pc, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc2", id_pc, 32'h0000_0000);
    chk("wrap_inst2", id_inst, 32'hA5A5_0000);

    // 6. asynchronous reset mid-cycle with a full queue
    id_ready = 1'b0;
    repeat (2) cyc();
    chk("pre_rst_valid", {31'b0, id_valid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_inst",  id_inst,           NOP);
    chk("arst_pc",    id_pc,             32'h0);
    chk("arst_ce",    {31'b0, rom_ce},   32'd0);
    chk("arst_addr",  rom_addr,          32'h0);
    cyc();
    rst = 1'b1; id_ready = 1'b1;
    cyc();
    chk("rr_ce",    {31'b0, rom_ce},   32'd1);
    chk("rr_valid", {31'b0, id_valid}, 32'd0);
    cyc();
    chk("rr_pc0", id_pc, 32'h0);
    cyc();
    chk("rr_pc1", id_pc, 32'h4);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction ROM.
- Owns the PC and drives the ROM chip-enable and address.
- Captures each returned instruction with its PC into a small fetch queue and presents it to ID over a valid/ready handshake.
- Absorbs ID back-pressure and branch/jump redirects without losing or duplicating instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
QDEPTH, 2, fetch-queue entries (power of two, >=2).

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-low reset.
rom_ce_o  output  1  ROM chip enable (ReadEnable when 1).
rom_addr_o  output  32  ROM byte address; always equals current PC.
rom_inst_i  input  32  instruction from ROM, valid in the same cycle as rom_addr_o.
jump_flag_i  input  1  redirect request from EX.
jump_addr_i  input  32  redirect target.
id_ready_i  input  1  ID accepts the head entry this cycle.
id_valid_o  output  1  head entry valid.
id_pc_o  output  32  PC of the head entry.
id_inst_o  output  32  instruction of the head entry.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, rom_ce_o=0, queue empty, id_valid_o=0, id_pc_o=ZeroWord, id_inst_o=INST_NOP (32'h0000_0013).
- rom_ce_o is a register: it rises to 1 on the first clock edge after rst deasserts and stays 1 until the next reset.
- rom_addr_o=pc at all times, combinationally from the pc register.
- pop = id_valid_o & id_ready_i.
- push = rom_ce_o & ~jump_flag_i & (count<QDEPTH | pop).
- On push:
  - Write {pc, rom_inst_i} at the tail.
  - pc <= pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- If push is not allowed (queue full and no pop): pc holds and the ROM is re-read next cycle.
- Simultaneous push and pop on a full queue is legal; count is unchanged.
- Redirect has top priority:
  - jump_flag_i=1 flushes the queue (count<=0, pointers<=0) and discards any pop/push that cycle.
  - pc <= {jump_addr_i[31:2], 2'b00}.
  - The first instruction from the target appears on id_* one cycle after the redirect edge, i.e. 1-cycle bubble minimum.
- ID handshake outputs:
  - id_valid_o = (count!=0).
  - id_pc_o/id_inst_o come from the head entry, muxed combinationally from registered storage.
  - When empty: ZeroWord / INST_NOP.
- Head data must stay stable while id_valid_o=1 and id_ready_i=0.
- Steady-state throughput: 1 instruction/cycle when id_ready_i is held at 1. Fetch-to-ID latency is 1 cycle: an instruction read in cycle N is visible at the ID port in cycle N+1.
- Queue:
  - Circular buffer with wrap-around pointers of log2(QDEPTH) bits.
  - count has log2(QDEPTH)+1 bits and never exceeds QDEPTH.
  - Pop on empty is impossible because pop is gated by id_valid_o.
- Reset mid-operation: all state returns to reset values immediately. Queued entries are lost, and fetch resumes at RESET_PC.

Decomposition:
- Shared defines header (existing core defines file):
  - ZeroWord, INST_NOP, ReadEnable/ReadDisable, InstAddrBus/InstBus widths.
  - New macro ResetPc, used as the RESET_PC default.
- One sub-module: fetch_queue.
  - Parameterised QDEPTH-entry, 64-bit-wide synchronous FIFO with flush, push, pop, full, empty and head outputs.
  - if_fetch holds the PC/redirect logic and instantiates it.

Test Plan:
1. Reset then release, ROM model returning inst=addr^32'hA5A5_0000, id_ready=1 -> cycle 0: ce=0, id_valid=0, id_inst=0x00000013. Then ce=1, and id_pc runs 0,4,8,... one per cycle with matching inst.
2. Back-pressure: id_ready=0 for 5 cycles after streaming starts -> count saturates at 2, id_pc/id_inst stable, pc frozen at head_pc+8. Release ready -> no instruction dropped or duplicated.
3. Redirect with full queue: jump_flag=1, jump_addr=0x0000_0103 -> queue flushed, next cycle id_valid=0 and rom_addr=0x100. Following cycle id_pc=0x100.
4. Redirect coinciding with id_ready=1 and valid head -> head not counted as consumed twice, no stale entry after redirect, id_pc sequence 0x200,0x204 after jump to 0x200.
5. Wrap: redirect to 0xFFFF_FFF8 -> id_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. Async reset asserted mid-cycle while queue holds 2 entries -> outputs go to reset values before the next clock edge. After release, fetch restarts at RESET_PC.
